// File: rtl/vending_ctrl.sv
// Vending machine controller: coin credit accumulation, product selection with price/stock checks,
// one-cycle dispense and unit-by-unit change return. Optional refund on `cancel` via VEND_CANCEL_EN.
module vending_ctrl #(
  parameter int                     NUM_PROD   = 4,
  parameter int                     CW         = 6,
  parameter int                     COIN_W     = 3,
  parameter logic [NUM_PROD*CW-1:0] PRICES     = {6'd12, 6'd9, 6'd7, 6'd4},
  parameter int                     STOCK_W    = 4,
  parameter int                     STOCK_INIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                sel_valid,
  input  logic [2:0]          sel_idx,
  input  logic                cancel,
  input  logic                restock,
  output logic                vend_valid,
  output logic [2:0]          vend_idx,
  output logic                chg_pulse,
  output logic [CW-1:0]       credit,
  output logic                busy,
  output logic                coin_rej,
  output logic                sel_rej,
  output logic [NUM_PROD-1:0] sold_out
);

  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      credit_nxt;
  logic [2:0]         vend_idx_nxt;
  logic               coin_rej_nxt, sel_rej_nxt;
  logic               stock_load, stock_dec;
  logic [STOCK_W-1:0] stock [NUM_PROD];

  logic               coin_live, coin_fits, cancel_req;
  logic [SW-1:0]      coin_sum;
  logic               sel_hit, sel_ok;
  logic [CW-1:0]      sel_price;
  logic [STOCK_W-1:0] sel_stock;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  logic unused_cancel;
  assign cancel_req    = 1'b0;
  assign unused_cancel = cancel;
`endif

  // Sum is one bit wider than credit so an overflow shows up in the top bit instead of wrapping.
  assign coin_live = coin_valid && (coin_val != '0);
  assign coin_sum  = {1'b0, credit} + SW'(coin_val);
  assign coin_fits = !coin_sum[CW];

  always_comb begin
    sel_hit   = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_hit   = 1'b1;
        sel_price = PRICES[i*CW +: CW];
        sel_stock = stock[i];
      end
    end
  end

  assign sel_ok = sel_valid && sel_hit && (sel_stock != '0) && (credit >= sel_price);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    vend_idx_nxt = '0;
    coin_rej_nxt = 1'b0;
    sel_rej_nxt  = 1'b0;
    stock_load   = 1'b0;
    stock_dec    = 1'b0;
    case (state)
      IDLE: begin
        stock_load  = restock;
        sel_rej_nxt = sel_valid;
        if (coin_live) begin
          if (coin_fits) begin
            credit_nxt = coin_sum[CW-1:0];
            state_nxt  = CREDIT;
          end else begin
            coin_rej_nxt = 1'b1;
          end
        end
      end
      CREDIT: begin
        if (cancel_req) begin
          state_nxt    = CHANGE;
          coin_rej_nxt = coin_live;
        end else if (sel_ok) begin
          state_nxt    = VEND;
          credit_nxt   = credit - sel_price;
          vend_idx_nxt = sel_idx;
          stock_dec    = 1'b1;
          coin_rej_nxt = coin_live;
        end else begin
          sel_rej_nxt = sel_valid;
          if (coin_live) begin
            if (coin_fits) credit_nxt = coin_sum[CW-1:0];
            else           coin_rej_nxt = 1'b1;
          end
        end
      end
      VEND: begin
        state_nxt    = (credit != '0) ? CHANGE : IDLE;
        coin_rej_nxt = coin_live;
        sel_rej_nxt  = sel_valid;
      end
      CHANGE: begin
        coin_rej_nxt = coin_live;
        sel_rej_nxt  = sel_valid;
        if (credit <= CW'(1)) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          credit_nxt = credit - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      credit     <= '0;
      vend_valid <= 1'b0;
      vend_idx   <= '0;
      chg_pulse  <= 1'b0;
      busy       <= 1'b0;
      coin_rej   <= 1'b0;
      sel_rej    <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      vend_valid <= (state_nxt == VEND);
      vend_idx   <= vend_idx_nxt;
      chg_pulse  <= (state_nxt == CHANGE);
      busy       <= (state_nxt == VEND) || (state_nxt == CHANGE);
      coin_rej   <= coin_rej_nxt;
      sel_rej    <= sel_rej_nxt;
    end
  end

  // NOTE: stock is functional state (it drives sold_out), so this small array is reset, unlike a data RAM.
  always_ff @(posedge clk) begin
    if (rst || stock_load) begin
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (stock_dec) begin
      for (int i = 0; i < NUM_PROD; i++) begin
        if (sel_idx == 3'(i)) stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) sold_out[i] = (stock[i] == '0);
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: directed scenarios plus $urandom traffic against a
// credit/stock reference model. Honors VEND_CANCEL_EN the same way the design does.
module tb_vending_ctrl;

  localparam int NUM_PROD   = 4;
  localparam int CW         = 6;
  localparam int COIN_W     = 3;
  localparam int STOCK_W    = 4;
  localparam int STOCK_INIT = 2;
  localparam int CREDIT_MAX = (1 << CW) - 1;
`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  int price_tab [NUM_PROD] = '{4, 7, 9, 12};

  logic                clk = 1'b0;
  logic                rst, coin_valid, sel_valid, cancel, restock;
  logic [COIN_W-1:0]   coin_val;
  logic [2:0]          sel_idx;
  logic                vend_valid, chg_pulse, busy, coin_rej, sel_rej;
  logic [2:0]          vend_idx;
  logic [CW-1:0]       credit;
  logic [NUM_PROD-1:0] sold_out;

  vending_ctrl #(
    .NUM_PROD(NUM_PROD), .CW(CW), .COIN_W(COIN_W),
    .PRICES({6'd12, 6'd9, 6'd7, 6'd4}),
    .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .restock(restock),
    .vend_valid(vend_valid), .vend_idx(vend_idx), .chg_pulse(chg_pulse), .credit(credit),
    .busy(busy), .coin_rej(coin_rej), .sel_rej(sel_rej), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: credit and stock as plain integers; a purchase occupies one dispense cycle,
  // then the remaining credit is paid back one unit per cycle.
  int m_credit;
  int m_stock [NUM_PROD];
  bit m_vending, m_paying, m_coin_rej, m_sel_rej;
  int m_vidx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit cv, input int cval, input bit sv,
                            input int sidx, input bit cn, input bit rs);
    bit coin_live;
    coin_live  = cv && (cval != 0);
    m_coin_rej = 1'b0;
    m_sel_rej  = 1'b0;
    if (r) begin
      m_credit  = 0;
      m_vending = 1'b0;
      m_paying  = 1'b0;
      m_vidx    = 0;
      for (int i = 0; i < NUM_PROD; i++) m_stock[i] = STOCK_INIT;
    end else if (m_vending) begin
      m_vending  = 1'b0;
      m_vidx     = 0;
      m_paying   = (m_credit > 0);
      m_coin_rej = coin_live;
      m_sel_rej  = sv;
    end else if (m_paying) begin
      m_credit   = m_credit - 1;
      m_paying   = (m_credit > 0);
      m_coin_rej = coin_live;
      m_sel_rej  = sv;
    end else begin
      if (rs && m_credit == 0)
        for (int i = 0; i < NUM_PROD; i++) m_stock[i] = STOCK_INIT;
      if (CANCEL_EN && cn && m_credit > 0) begin
        m_paying   = 1'b1;
        m_coin_rej = coin_live;
      end else if (sv && sidx < NUM_PROD && m_credit >= price_tab[sidx] && m_stock[sidx] > 0) begin
        m_credit         = m_credit - price_tab[sidx];
        m_stock[sidx]    = m_stock[sidx] - 1;
        m_vending        = 1'b1;
        m_vidx           = sidx;
        m_coin_rej       = coin_live;
      end else begin
        m_sel_rej = sv;
        if (coin_live) begin
          if (m_credit + cval <= CREDIT_MAX) m_credit = m_credit + cval;
          else                               m_coin_rej = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_PROD-1:0] exp_so;
    for (int i = 0; i < NUM_PROD; i++) exp_so[i] = (m_stock[i] == 0);
    check("vend_valid", 32'(vend_valid), 32'(m_vending));
    check("vend_idx",   32'(vend_idx),   32'(m_vending ? m_vidx : 0));
    check("chg_pulse",  32'(chg_pulse),  32'(m_paying));
    check("busy",       32'(busy),       32'(m_vending || m_paying));
    check("credit",     32'(credit),     32'(m_credit));
    check("coin_rej",   32'(coin_rej),   32'(m_coin_rej));
    check("sel_rej",    32'(sel_rej),    32'(m_sel_rej));
    check("sold_out",   32'(sold_out),   32'(exp_so));
  endtask

  task automatic tick(input bit r, input bit cv, input int cval, input bit sv,
                      input int sidx, input bit cn, input bit rs);
    rst        = r;
    coin_valid = cv;
    coin_val   = COIN_W'(cval);
    sel_valid  = sv;
    sel_idx    = 3'(sidx);
    cancel     = cn;
    restock    = rs;
    @(posedge clk);
    model_step(r, cv, cval, sv, sidx, cn, rs);
    #1;
    compare_all();
  endtask

  task automatic idle_t();          tick(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic coin_t(input int v); tick(0, 1, v, 0, 0, 0, 0); endtask
  task automatic sel_t(input int i);  tick(0, 0, 0, 1, i, 0, 0); endtask
  task automatic reset_t();         tick(1, 0, 0, 0, 0, 0, 0); endtask

  task automatic drain();
    for (int i = 0; i < 80 && busy; i++) idle_t();
    check("drain_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset_t();
    reset_t();
    check("reset_credit", 32'(credit), 32'(0));
    check("reset_sold_out", 32'(sold_out), 32'(0));

    // Coins 2 and 3, buy product 0 (price 4): dispense next cycle, then one unit of change.
    coin_t(2);
    coin_t(3);
    sel_t(0);
    check("r037_vend", 32'(vend_valid), 32'(1));
    check("r037_credit", 32'(credit), 32'(1));
    idle_t();
    check("r037_chg", 32'(chg_pulse), 32'(1));
    idle_t();
    check("r037_idle_busy", 32'(busy), 32'(0));
    check("r037_idle_credit", 32'(credit), 32'(0));

    // Credit 5 is short of product 2 (price 9).
    coin_t(2);
    coin_t(3);
    sel_t(2);
    check("r038_sel_rej", 32'(sel_rej), 32'(1));
    check("r038_credit", 32'(credit), 32'(5));
    sel_t(0);
    drain();

    // Sell product 0 out with two exact purchases, then restock.
    reset_t();
    for (int k = 0; k < 2; k++) begin
      coin_t(4);
      sel_t(0);
      idle_t();
    end
    check("r039_sold_out", 32'(sold_out[0]), 32'(1));
    coin_t(4);
    sel_t(0);
    check("r039_sel_rej", 32'(sel_rej), 32'(1));
    coin_t(3);
    sel_t(1);
    drain();
    tick(0, 0, 0, 0, 0, 0, 1);
    check("r039_restock", 32'(sold_out[0]), 32'(0));

    // Credit ceiling: 60 + 4 overflows, 60 + 3 lands exactly on 63.
    for (int k = 0; k < 8; k++) coin_t(7);
    coin_t(4);
    check("r040_credit60", 32'(credit), 32'(60));
    coin_t(4);
    check("r040_coin_rej", 32'(coin_rej), 32'(1));
    check("r040_hold", 32'(credit), 32'(60));
    coin_t(3);
    check("r040_credit63", 32'(credit), 32'(63));
    sel_t(3);
    drain();

    // Cancel with 7 credit.
    coin_t(7);
    tick(0, 0, 0, 0, 0, 1, 0);
    check("r041_busy", 32'(busy), 32'(CANCEL_EN));
    pulses = int'(chg_pulse);
    for (int k = 0; k < 19; k++) begin
      idle_t();
      pulses += int'(chg_pulse);
    end
    check("r041_pulses", 32'(pulses), CANCEL_EN ? 32'(7) : 32'(0));
    check("r041_credit", 32'(credit), CANCEL_EN ? 32'(0) : 32'(7));
    if (credit != '0) begin
      sel_t(1);
      drain();
    end

    // Reset during the second change cycle.
    coin_t(7);
    sel_t(0);
    idle_t();
    idle_t();
    check("r042_in_change", 32'(chg_pulse), 32'(1));
    reset_t();
    check("r042_chg", 32'(chg_pulse), 32'(0));
    check("r042_credit", 32'(credit), 32'(0));
    check("r042_busy", 32'(busy), 32'(0));
    check("r042_stock", 32'(sold_out), 32'(0));
    idle_t();
    check("r042_no_pulse", 32'(chg_pulse), 32'(0));

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      tick($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 14) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 Parameter NUM_PROD, default 4: number of products, 2..8.
REQ-002 Parameter CW, default 6: credit register width; CREDIT_MAX = 2^CW-1.
REQ-003 Parameter COIN_W, default 3: coin value width.
REQ-004 Parameter PRICES, default {6'd12,6'd9,6'd7,6'd4}: packed NUM_PROD*CW prices, product 0 in the LSBs; every price SHALL be >0.
REQ-005 Parameter STOCK_W, default 4: per-product stock counter width.
REQ-006 Parameter STOCK_INIT, default 2: stock loaded at reset and restock.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 coin_valid  in  1  coin present this cycle.
REQ-010 coin_val  in  COIN_W  coin value in credit units; value 0 is ignored.
REQ-011 sel_valid  in  1  selection request this cycle.
REQ-012 sel_idx  in  3  product index.
REQ-013 cancel  in  1  refund request; used only with VEND_CANCEL_EN.
REQ-014 restock  in  1  reload all stock counters.
REQ-015 vend_valid  out  1  product dispensed, one-cycle pulse.
REQ-016 vend_idx  out  3  dispensed product index, valid with vend_valid; 0 otherwise.
REQ-017 chg_pulse  out  1  one credit unit returned this cycle.
REQ-018 credit  out  CW  current credit register.
REQ-019 busy  out  1  high in VEND and CHANGE.
REQ-020 coin_rej  out  1  registered pulse one cycle after a rejected coin.
REQ-021 sel_rej  out  1  registered pulse one cycle after a rejected selection.
REQ-022 sold_out  out  NUM_PROD  bit i high when stock[i]==0.

Function
REQ-023 The FSM SHALL have states IDLE, CREDIT, VEND and CHANGE; all outputs are registered.
REQ-024 IDLE: accepted coin -> credit=coin_val, next CREDIT; selection -> sel_rej; restock accepted only in IDLE.
REQ-025 CREDIT: coin accepted when credit+coin_val <= CREDIT_MAX, else coin_rej, credit unchanged; arithmetic at CW+1 bits, no wrap.
REQ-026 CREDIT selection: sel_idx>=NUM_PROD, stock==0 or credit<price -> sel_rej, stay CREDIT; otherwise next VEND.
REQ-027 Same cycle coin and accepted selection: selection wins, coin rejected (coin_rej); selection is judged on the registered credit, not credit+coin; when the selection is rejected, the coin is processed per REQ-025.
REQ-028 VEND lasts exactly one cycle: vend_valid=1, vend_idx=selected index, credit-=price, stock[idx]-=1; next CHANGE if remainder>0, else IDLE.
REQ-029 CHANGE: chg_pulse=1 every cycle, credit-=1 per cycle; the cycle credit reaches 0 -> next IDLE; N credit remaining yields exactly N pulses.
REQ-030 Coins in VEND/CHANGE SHALL be rejected (coin_rej); selections there SHALL raise sel_rej; restock outside IDLE ignored.
REQ-031 Latency: accepted selection to vend_valid is exactly 1 cycle.
REQ-032 Stock counters SHALL never underflow; sold_out tracks them combinationally from the registers.

Reset
REQ-033 On rst: state IDLE, credit 0, every stock = STOCK_INIT, all pulses and vend_idx 0, busy 0.
REQ-034 rst mid-CREDIT or mid-CHANGE SHALL discard outstanding credit; no further chg_pulse.

Configuration
REQ-035 Macro VEND_CANCEL_EN defined: cancel in CREDIT -> next CHANGE returning all credit; cancel beats selection and coin (coin rejected); cancel elsewhere ignored.
REQ-036 Macro undefined: cancel port present but ignored; credit held until a purchase.

Verification
REQ-037 Coins 2,3 then sel_idx 0 -> vend_valid/vend_idx 0 one cycle later, one chg_pulse, IDLE, credit 0.
REQ-038 Credit 5, sel_idx 2 (price 9) -> sel_rej pulse, credit stays 5, state CREDIT.
REQ-039 Two exact-4 purchases of product 0 -> sold_out[0]=1; third attempt with credit 4 -> sel_rej; restock in IDLE -> sold_out[0]=0.
REQ-040 Credit 60, coin 4 -> coin_rej, credit 60; coin 3 -> credit 63.
REQ-041 Credit 7, cancel: with VEND_CANCEL_EN 7 chg_pulses, busy high, IDLE credit 0; without, credit stays 7, no pulses.
REQ-042 rst asserted in 2nd CHANGE cycle -> next cycle all outputs 0, credit 0, stock STOCK_INIT.
